// File: rtl/alu_pkg.sv
// Shared ALU definitions: control codes, writeback exception codes and state
// encoding, plus helpers that classify control codes.
package alu_pkg;

  localparam logic [3:0] CTRL_ADD   = 4'h1;
  localparam logic [3:0] CTRL_SUB   = 4'h2;
  localparam logic [3:0] CTRL_MUL   = 4'h4;
  localparam logic [3:0] CTRL_DIV   = 4'h8;
  localparam logic [3:0] CTRL_ANDI  = 4'hC;
  localparam logic [3:0] CTRL_ORI   = 4'hE;
  localparam logic [3:0] CTRL_ADDNF = 4'hF;

  typedef enum logic [1:0] {
    EXC_NONE = 2'b00,
    EXC_OVF  = 2'b01,
    EXC_ILL  = 2'b10
  } exc_code_t;

  typedef enum logic [1:0] {
    WB_IDLE    = 2'd0,
    WB_WR_MAIN = 2'd1,
    WB_WR_R0   = 2'd2,
    WB_EXC     = 2'd3
  } wb_state_t;

  function automatic logic is_legal_ctrl(input logic [3:0] ctrl);
    case (ctrl)
      CTRL_ADD, CTRL_SUB, CTRL_MUL, CTRL_DIV,
      CTRL_ANDI, CTRL_ORI, CTRL_ADDNF: is_legal_ctrl = 1'b1;
      default:                         is_legal_ctrl = 1'b0;
    endcase
  endfunction

  // Multiply and divide also produce an R0 result (high product / remainder).
  function automatic logic is_dual_write(input logic [3:0] ctrl);
    is_dual_write = (ctrl == CTRL_MUL) || (ctrl == CTRL_DIV);
  endfunction

endpackage

// File: rtl/alu_writeback.sv
// Retires ALU result bundles into the register file: one write, or two
// (destination then R0) for mul/div; faults park in a sticky exception state.
module alu_writeback
  import alu_pkg::*;
#(
  parameter int                DATA_W  = 16,
  parameter int                ADDR_W  = 4,
  parameter logic [ADDR_W-1:0] R0_ADDR = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_ctrl,
  input  logic [DATA_W-1:0] in_out,
  input  logic [DATA_W-1:0] in_r0,
  input  logic              in_ovf,
  input  logic [ADDR_W-1:0] in_dest,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  input  logic              rf_ready,
  output logic              exc,
  output logic [1:0]        exc_code,
  input  logic              exc_clr,
  output logic [7:0]        ovf_count
);

  // Handshakes: a bundle transfers on a rising edge with in_valid & in_ready;
  // a register-file write commits on a rising edge with rf_we & rf_ready, and
  // rf_waddr/rf_wdata hold steady while rf_we waits for rf_ready.

  wb_state_t         state, state_n;
  exc_code_t         exc_code_q;
  logic [3:0]        cap_ctrl;
  logic [DATA_W-1:0] cap_out;
  logic [DATA_W-1:0] cap_r0;
  logic [ADDR_W-1:0] cap_dest;
  logic [7:0]        ovf_count_q;
  logic              accept;

  assign in_ready  = (state == WB_IDLE);
  assign accept    = in_valid && in_ready;
  assign exc       = (state == WB_EXC);
  assign exc_code  = exc_code_q;
  assign ovf_count = ovf_count_q;

  always_comb begin
    state_n = state;
    case (state)
      WB_IDLE: begin
        if (accept) begin
          if (!is_legal_ctrl(in_ctrl) || in_ovf) state_n = WB_EXC;
          else                                   state_n = WB_WR_MAIN;
        end
      end
      WB_WR_MAIN: begin
        if (rf_ready) state_n = is_dual_write(cap_ctrl) ? WB_WR_R0 : WB_IDLE;
      end
      WB_WR_R0: begin
        if (rf_ready) state_n = WB_IDLE;
      end
      WB_EXC: begin
        if (exc_clr) state_n = WB_IDLE;
      end
      default: state_n = WB_IDLE;
    endcase
  end

  // Write port is a pure decode of state and capture registers.
  always_comb begin
    rf_we    = 1'b0;
    rf_waddr = '0;
    rf_wdata = '0;
    case (state)
      WB_WR_MAIN: begin
        rf_we    = 1'b1;
        rf_waddr = cap_dest;
        rf_wdata = cap_out;
      end
      WB_WR_R0: begin
        rf_we    = 1'b1;
        rf_waddr = R0_ADDR;
        rf_wdata = cap_r0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= WB_IDLE;
      exc_code_q  <= EXC_NONE;
      cap_ctrl    <= '0;
      cap_out     <= '0;
      cap_r0      <= '0;
      cap_dest    <= '0;
      ovf_count_q <= '0;
    end else begin
      state <= state_n;
      if (accept) begin
        cap_ctrl <= in_ctrl;
        cap_out  <= in_out;
        cap_r0   <= in_r0;
        cap_dest <= in_dest;
        // Illegal control outranks overflow; only overflow is counted.
        if (!is_legal_ctrl(in_ctrl)) begin
          exc_code_q <= EXC_ILL;
        end else if (in_ovf) begin
          exc_code_q <= EXC_OVF;
          if (ovf_count_q != 8'hFF) ovf_count_q <= ovf_count_q + 8'd1;
        end
      end else if (state == WB_EXC && exc_clr) begin
        exc_code_q <= EXC_NONE;
      end
    end
  end

endmodule

// File: tb/tb_alu_writeback.sv
// Directed bench for alu_writeback: expected register-file writes are queued
// by the driver and checked by an independent monitor on the falling edge.
module tb_alu_writeback;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 4;
  localparam int WR_W   = ADDR_W + DATA_W;

  logic              clk;
  logic              reset;
  logic              in_valid;
  logic              in_ready;
  logic [3:0]        in_ctrl;
  logic [DATA_W-1:0] in_out;
  logic [DATA_W-1:0] in_r0;
  logic              in_ovf;
  logic [ADDR_W-1:0] in_dest;
  logic              rf_we;
  logic [ADDR_W-1:0] rf_waddr;
  logic [DATA_W-1:0] rf_wdata;
  logic              rf_ready;
  logic              exc;
  logic [1:0]        exc_code;
  logic              exc_clr;
  logic [7:0]        ovf_count;

  logic [WR_W-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  int exp_ovf = 0;

  alu_writeback #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .R0_ADDR(4'd0)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_ctrl(in_ctrl),
    .in_out(in_out), .in_r0(in_r0), .in_ovf(in_ovf), .in_dest(in_dest),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .rf_ready(rf_ready),
    .exc(exc), .exc_code(exc_code), .exc_clr(exc_clr), .ovf_count(ovf_count)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: act=timeout req=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: act=0x%0h req=0x%0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic logic model_legal(input logic [3:0] c);
    return (c == 4'h1) || (c == 4'h2) || (c == 4'h4) || (c == 4'h8) ||
           (c == 4'hC) || (c == 4'hE) || (c == 4'hF);
  endfunction

  // Driver: waits for in_ready, presents one bundle for one edge, queues writes.
  task automatic send(input logic [3:0] c, input logic [DATA_W-1:0] o,
                      input logic [DATA_W-1:0] r, input logic v, input logic [ADDR_W-1:0] d);
    int n = 0;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL send_wait: act=in_ready 0 req=in_ready 1 within 50 cycles");
    end
    in_valid = 1'b1;
    in_ctrl  = c;
    in_out   = o;
    in_r0    = r;
    in_ovf   = v;
    in_dest  = d;
    if (model_legal(c) && !v) begin
      exp_q.push_back({d, o});
      if (c == 4'h4 || c == 4'h8) exp_q.push_back({4'd0, r});
    end else if (model_legal(c) && exp_ovf < 255) begin
      exp_ovf++;
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic clear_exc();
    @(negedge clk);
    exc_clr = 1'b1;
    @(posedge clk);
    #1 exc_clr = 1'b0;
    check("clr_exc", {31'd0, exc}, 32'd0);
    check("clr_code", {30'd0, exc_code}, 32'd0);
    check("clr_in_ready", {31'd0, in_ready}, 32'd1);
  endtask

  // Scoreboard monitor: every committed write must match the queue head.
  always @(negedge clk) begin
    if (reset && rf_we && rf_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: act=%0h/%0h req=none", rf_waddr, rf_wdata);
      end else begin
        logic [WR_W-1:0] e;
        e = exp_q.pop_front();
        if ({rf_waddr, rf_wdata} !== e) begin
          errors++;
          $display("FAIL write: act=%0h/%0h req=%0h/%0h",
                   rf_waddr, rf_wdata, e[WR_W-1:DATA_W], e[DATA_W-1:0]);
        end
      end
    end
  end

  initial begin
    reset = 1'b0; in_valid = 1'b0; in_ctrl = '0; in_out = '0; in_r0 = '0;
    in_ovf = 1'b0; in_dest = '0; rf_ready = 1'b1; exc_clr = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_rf_we", {31'd0, rf_we}, 32'd0);
    check("rst_exc", {31'd0, exc}, 32'd0);
    check("rst_ovf_count", {24'd0, ovf_count}, 32'd0);
    @(negedge clk);
    reset = 1'b1;

    // Add retire: single write then back to IDLE
    send(4'h1, 16'h0007, 16'h0000, 1'b0, 4'd3);
    check("add_we", {31'd0, rf_we}, 32'd1);
    check("add_busy", {31'd0, in_ready}, 32'd0);
    @(posedge clk); #1;
    check("add_done_we", {31'd0, rf_we}, 32'd0);
    check("add_done_ready", {31'd0, in_ready}, 32'd1);

    // Mul: main write then R0 write on consecutive cycles
    send(4'h4, 16'h2000, 16'h0001, 1'b0, 4'd5);
    check("mul_main_addr", {28'd0, rf_waddr}, 32'd5);
    @(posedge clk); #1;
    check("mul_r0_we", {31'd0, rf_we}, 32'd1);
    check("mul_r0_addr", {28'd0, rf_waddr}, 32'd0);
    check("mul_r0_data", {16'd0, rf_wdata}, 32'h0001);
    @(posedge clk); #1;
    check("mul_done_ready", {31'd0, in_ready}, 32'd1);

    // Div with backpressure on the main write
    rf_ready = 1'b0;
    send(4'h8, 16'h0003, 16'h0002, 1'b0, 4'd2);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_we", {31'd0, rf_we}, 32'd1);
      check("bp_addr", {28'd0, rf_waddr}, 32'd2);
      check("bp_data", {16'd0, rf_wdata}, 32'h0003);
      check("bp_busy", {31'd0, in_ready}, 32'd0);
      @(posedge clk); #1;
    end
    rf_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_r0_addr", {28'd0, rf_waddr}, 32'd0);
    check("bp_r0_busy", {31'd0, in_ready}, 32'd0);
    @(posedge clk); #1;
    check("bp_done_ready", {31'd0, in_ready}, 32'd1);

    // Mul writing R0 as destination: both writes, R0 value last
    send(4'h4, 16'hAAAA, 16'h5555, 1'b0, 4'd0);
    repeat (2) @(posedge clk);

    // Overflow fault
    send(4'h1, 16'h7FFF, 16'h0000, 1'b1, 4'd6);
    check("ovf_exc", {31'd0, exc}, 32'd1);
    check("ovf_code", {30'd0, exc_code}, 32'd1);
    check("ovf_count1", {24'd0, ovf_count}, 32'd1);
    check("ovf_no_we", {31'd0, rf_we}, 32'd0);
    clear_exc();

    // Illegal ctrl: code 10, counter untouched
    send(4'h3, 16'h1234, 16'h0000, 1'b1, 4'd1);
    check("ill_exc", {31'd0, exc}, 32'd1);
    check("ill_code", {30'd0, exc_code}, 32'd2);
    check("ill_count", {24'd0, ovf_count}, 32'd1);
    clear_exc();

    // 256 overflow faults drive the counter into saturation
    for (int i = 0; i < 256; i++) begin
      send(4'h2, 16'h8000, 16'h0000, 1'b1, 4'd7);
      if (i >= 250) check("sat_count", {24'd0, ovf_count}, exp_ovf);
      clear_exc();
    end
    check("sat_final", {24'd0, ovf_count}, 32'd255);

    // Reset during WR_R0: R0 write must be abandoned
    send(4'h8, 16'h0011, 16'h0022, 1'b0, 4'd9);
    void'(exp_q.pop_back());
    @(posedge clk); #1;
    check("rst_mid_we", {31'd0, rf_we}, 32'd1);
    check("rst_mid_addr", {28'd0, rf_waddr}, 32'd0);
    reset = 1'b0;
    #1;
    check("rst_async_we", {31'd0, rf_we}, 32'd0);
    check("rst_async_addr", {28'd0, rf_waddr}, 32'd0);
    check("rst_async_data", {16'd0, rf_wdata}, 32'd0);
    check("rst_async_ready", {31'd0, in_ready}, 32'd1);
    check("rst_async_count", {24'd0, ovf_count}, 32'd0);
    check("rst_async_code", {30'd0, exc_code}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    repeat (4) begin
      @(posedge clk); #1;
      check("post_rst_we", {31'd0, rf_we}, 32'd0);
    end

    check("queue_empty", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
